// File: rtl/dtm_jtag.sv
// RISC-V debug transport module over a JTAG TAP: 6-bit IR selecting IDCODE,
// DTMCS, DMI or BYPASS, with a single-outstanding DMI request handshake.
module dtm_jtag (
  input  logic         tclk,
  input  logic         trst,
  input  logic         tms,
  input  logic         tdi,
  output logic         tdo,
  output logic         tdo_en,
  output logic         dmi_start,
  input  logic         dmi_finish,
  output logic [1:0]   dmi_op,
  output logic [40:34] dmi_address,
  output logic [33:2]  dmi_data_o,
  input  logic [33:2]  dmi_data_i
);

  localparam logic [3:0] TEST_LOGIC_RESET = 4'd0;
  localparam logic [3:0] RUN_TEST_IDLE    = 4'd1;
  localparam logic [3:0] SELECT_DR_SCAN   = 4'd2;
  localparam logic [3:0] CAPTURE_DR       = 4'd3;
  localparam logic [3:0] SHIFT_DR         = 4'd4;
  localparam logic [3:0] EXIT1_DR         = 4'd5;
  localparam logic [3:0] PAUSE_DR         = 4'd6;
  localparam logic [3:0] EXIT2_DR         = 4'd7;
  localparam logic [3:0] UPDATE_DR        = 4'd8;
  localparam logic [3:0] SELECT_IR_SCAN   = 4'd9;
  localparam logic [3:0] CAPTURE_IR       = 4'd10;
  localparam logic [3:0] SHIFT_IR         = 4'd11;
  localparam logic [3:0] EXIT1_IR         = 4'd12;
  localparam logic [3:0] PAUSE_IR         = 4'd13;
  localparam logic [3:0] EXIT2_IR         = 4'd14;
  localparam logic [3:0] UPDATE_IR        = 4'd15;

  localparam logic [5:0] IR_IDCODE = 6'h01;
  localparam logic [5:0] IR_DTMCS  = 6'h10;
  localparam logic [5:0] IR_DMI    = 6'h11;

  localparam logic [1:0] SEL_BYPASS = 2'd0;
  localparam logic [1:0] SEL_IDCODE = 2'd1;
  localparam logic [1:0] SEL_DTMCS  = 2'd2;
  localparam logic [1:0] SEL_DMI    = 2'd3;

  localparam logic [31:0] IDCODE_VALUE = 32'h1BEEF001;

  logic [3:0]  state;
  logic [5:0]  ir;
  logic [3:0]  next_state_s;
  logic [1:0]  sel_s;
  logic [5:0]  ir_shift_r;
  logic [40:0] dr_shift_r;
  logic [40:0] dr_capture_s;
  logic [40:0] dr_shifted_s;
  logic [31:0] dtmcs_s;
  logic [31:0] read_data_r;
  logic [1:0]  dmistat_r;
  logic        busy_r;
  logic        capture_busy_r;

  assign tdo_en  = (state == SHIFT_DR) || (state == SHIFT_IR);
  assign dtmcs_s = {17'd0, 3'd0, dmistat_r, 6'd7, 4'd1};

  // TAP next-state decode
  always_comb begin
    next_state_s = state;
    case (state)
      TEST_LOGIC_RESET: next_state_s = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    next_state_s = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   next_state_s = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       next_state_s = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         next_state_s = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         next_state_s = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         next_state_s = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         next_state_s = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        next_state_s = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   next_state_s = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       next_state_s = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         next_state_s = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         next_state_s = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         next_state_s = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         next_state_s = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        next_state_s = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          next_state_s = TEST_LOGIC_RESET;
    endcase
  end

  // Data register selection, capture value and one-bit shift per register length
  always_comb begin
    sel_s        = SEL_BYPASS;
    dr_capture_s = 41'd0;
    dr_shifted_s = {40'd0, tdi};
    case (ir)
      IR_IDCODE: sel_s = SEL_IDCODE;
      IR_DTMCS:  sel_s = SEL_DTMCS;
      IR_DMI:    sel_s = SEL_DMI;
      default:   sel_s = SEL_BYPASS;
    endcase
    case (sel_s)
      SEL_IDCODE: begin
        dr_capture_s = {9'd0, IDCODE_VALUE};
        dr_shifted_s = {9'd0, tdi, dr_shift_r[31:1]};
      end
      SEL_DTMCS: begin
        dr_capture_s = {9'd0, dtmcs_s};
        dr_shifted_s = {9'd0, tdi, dr_shift_r[31:1]};
      end
      SEL_DMI: begin
        dr_capture_s = {dmi_address, read_data_r, (busy_r ? 2'd3 : 2'd0)};
        dr_shifted_s = {tdi, dr_shift_r[40:1]};
      end
      default: begin
        dr_capture_s = 41'd0;
        dr_shifted_s = {40'd0, tdi};
      end
    endcase
  end

  // TAP state, IR/DR shift paths and DMI request tracking
  always_ff @(posedge tclk or negedge trst) begin
    if (!trst) begin
      state          <= TEST_LOGIC_RESET;
      ir             <= IR_IDCODE;
      ir_shift_r     <= 6'd0;
      dr_shift_r     <= 41'd0;
      read_data_r    <= 32'd0;
      dmistat_r      <= 2'd0;
      busy_r         <= 1'b0;
      capture_busy_r <= 1'b0;
      dmi_start      <= 1'b0;
      dmi_op         <= 2'd0;
      dmi_address    <= 7'd0;
      dmi_data_o     <= 32'd0;
    end else begin
      state     <= next_state_s;
      dmi_start <= 1'b0;
      case (state)
        CAPTURE_IR: ir_shift_r <= 6'b000001;
        SHIFT_IR:   ir_shift_r <= {tdi, ir_shift_r[5:1]};
        UPDATE_IR:  ir         <= ir_shift_r;
        CAPTURE_DR: begin
          dr_shift_r <= dr_capture_s;
          if ((sel_s == SEL_DMI) && busy_r) begin
            capture_busy_r <= 1'b1;
            dmistat_r      <= 2'd3;
          end
        end
        SHIFT_DR:   dr_shift_r <= dr_shifted_s;
        UPDATE_DR: begin
          // A scan that captured busy is discarded even if the DM finished meanwhile
          if (sel_s == SEL_DMI) begin
            capture_busy_r <= 1'b0;
            if (!busy_r && !capture_busy_r &&
                ((dr_shift_r[1:0] == 2'd1) || (dr_shift_r[1:0] == 2'd2))) begin
              dmi_op      <= dr_shift_r[1:0];
              dmi_address <= dr_shift_r[40:34];
              dmi_data_o  <= dr_shift_r[33:2];
              dmi_start   <= 1'b1;
              busy_r      <= 1'b1;
            end
          end else if (sel_s == SEL_DTMCS) begin
            if (dr_shift_r[16] || dr_shift_r[17]) begin
              dmistat_r <= 2'd0;
            end
            if (dr_shift_r[17]) begin
              busy_r <= 1'b0;
            end
          end
        end
        default: ;
      endcase
      if (dmi_finish && busy_r) begin
        read_data_r <= dmi_data_i;
        busy_r      <= 1'b0;
      end
      if (next_state_s == TEST_LOGIC_RESET) begin
        ir             <= IR_IDCODE;
        busy_r         <= 1'b0;
        dmistat_r      <= 2'd0;
        capture_busy_r <= 1'b0;
      end
    end
  end

  // Serial output changes on the falling edge so the host samples a settled bit
  always_ff @(negedge tclk or negedge trst) begin
    if (!trst) begin
      tdo <= 1'b0;
    end else if (state == SHIFT_DR) begin
      tdo <= dr_shift_r[0];
    end else if (state == SHIFT_IR) begin
      tdo <= ir_shift_r[0];
    end else begin
      tdo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dtm_jtag.sv
// Scoreboard bench for dtm_jtag: expected scan captures and DMI requests are
// queued when stimulus is issued and compared when the DUT produces them.
module tb_dtm_jtag;

  localparam logic [3:0] ST_TLR = 4'd0;
  localparam logic [3:0] ST_RTI = 4'd1;

  logic         tclk;
  logic         trst;
  logic         tms;
  logic         tdi;
  logic         tdo;
  logic         tdo_en;
  logic         dmi_start;
  logic         dmi_finish;
  logic [1:0]   dmi_op;
  logic [40:34] dmi_address;
  logic [33:2]  dmi_data_o;
  logic [33:2]  dmi_data_i;

  int checks   = 0;
  int failures = 0;
  int starts   = 0;

  logic [40:0] exp_scan_q[$];
  logic [40:0] exp_dmi_q[$];
  logic [40:0] got;
  logic [40:0] exp_v;

  dtm_jtag dut (
    .tclk        (tclk),
    .trst        (trst),
    .tms         (tms),
    .tdi         (tdi),
    .tdo         (tdo),
    .tdo_en      (tdo_en),
    .dmi_start   (dmi_start),
    .dmi_finish  (dmi_finish),
    .dmi_op      (dmi_op),
    .dmi_address (dmi_address),
    .dmi_data_o  (dmi_data_o),
    .dmi_data_i  (dmi_data_i)
  );

  initial tclk = 1'b0;
  always #5 tclk = ~tclk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // DMI request monitor: every dmi_start must match the oldest queued request
  always @(negedge tclk) begin
    if (trst === 1'b1 && dmi_start === 1'b1) begin
      starts++;
      if (exp_dmi_q.size() == 0) begin
        check_eq("dmi_unexpected", 64'(1'b1), 64'(1'b0));
      end else begin
        check_eq("dmi_request", 64'({dmi_op, dmi_address, dmi_data_o}), 64'(exp_dmi_q.pop_front()));
      end
    end
  end

  task automatic tick(input logic m, input logic d, output logic o);
    tms = m;
    tdi = d;
    @(negedge tclk);
    #1 o = tdo;
    @(posedge tclk);
    #1;
  endtask

  task automatic ir_scan(input logic [5:0] v);
    logic o;
    logic [5:0] vv;
    vv = v;
    tick(1'b1, 1'b0, o);
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    tick(1'b0, 1'b0, o);
    for (int i = 0; i < 6; i++) tick(i == 5, vv[i], o);
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
  endtask

  task automatic dr_scan(input int n, input logic [40:0] din, output logic [40:0] dout);
    logic o;
    dout = 41'd0;
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    tick(1'b0, 1'b0, o);
    check_eq("tdo_en_shift", 64'(tdo_en), 64'(1'b1));
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, din[i], o);
      dout[i] = o;
    end
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
  endtask

  task automatic scan_check(input string tag, input int n, input logic [40:0] din);
    logic [40:0] r;
    dr_scan(n, din, r);
    check_eq(tag, 64'(r), 64'(exp_scan_q.pop_front()));
  endtask

  task automatic pulse_finish(input logic [31:0] d);
    dmi_data_i = d;
    dmi_finish = 1'b1;
    @(posedge tclk);
    #1 dmi_finish = 1'b0;
    @(posedge tclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic o;
    trst = 1'b1; tms = 1'b1; tdi = 1'b0;
    dmi_finish = 1'b0; dmi_data_i = 32'd0;
    #2 trst = 1'b0;
    #1;
    check_eq("rst_state", 64'(dut.state), 64'(ST_TLR));
    check_eq("rst_ir", 64'(dut.ir), 64'(6'h01));
    check_eq("rst_outs", 64'({tdo, dmi_start, dmi_op, dmi_address, dmi_data_o}), 64'(0));
    @(posedge tclk);
    #1 trst = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, o);
    check_eq("tlr_after_5", 64'(dut.state), 64'(ST_TLR));
    tick(1'b0, 1'b0, o);
    check_eq("rti", 64'(dut.state), 64'(ST_RTI));

    exp_scan_q.push_back(41'h1BEEF001);
    scan_check("idcode", 32, 41'd0);
    check_eq("rti_after_dr", 64'(dut.state), 64'(ST_RTI));
    check_eq("tdo_en_idle", 64'(tdo_en), 64'(1'b0));

    ir_scan(6'b101010);
    check_eq("ir_101010", 64'(dut.ir), 64'(6'b101010));
    exp_scan_q.push_back(41'd0);
    scan_check("bypass_zero", 32, 41'd0);
    exp_scan_q.push_back(41'h04B4B4B4A);
    scan_check("bypass_delay", 32, 41'h0A5A5A5A5);

    // Park in SHIFT_DR then five tms=1 edges must land in reset
    tick(1'b1, 1'b0, o);
    tick(1'b0, 1'b0, o);
    tick(1'b0, 1'b0, o);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, o);
    check_eq("tlr_from_shift", 64'(dut.state), 64'(ST_TLR));
    check_eq("tlr_ir_idcode", 64'(dut.ir), 64'(6'h01));
    tick(1'b0, 1'b0, o);

    ir_scan(6'h10);
    exp_scan_q.push_back(41'h71);
    scan_check("dtmcs_idle", 32, 41'd0);

    ir_scan(6'h11);
    exp_scan_q.push_back(41'd0);
    exp_dmi_q.push_back({2'd2, 7'h10, 32'h1});
    scan_check("dmi_write_cap", 41, {7'h10, 32'h1, 2'd2});
    check_eq("dmi_out_op", 64'(dmi_op), 64'(2'd2));
    check_eq("dmi_out_addr", 64'(dmi_address), 64'(7'h10));
    check_eq("dmi_out_data", 64'(dmi_data_o), 64'(32'h1));

    exp_scan_q.push_back({7'h10, 32'h0, 2'd3});
    scan_check("dmi_busy_cap", 41, {7'h11, 32'h0, 2'd1});
    pulse_finish(32'h12345678);

    ir_scan(6'h10);
    exp_scan_q.push_back(41'hC71);
    scan_check("dtmcs_sticky", 32, 41'h10000);
    exp_scan_q.push_back(41'h71);
    scan_check("dtmcs_cleared", 32, 41'd0);

    ir_scan(6'h11);
    exp_scan_q.push_back({7'h10, 32'h12345678, 2'd0});
    exp_dmi_q.push_back({2'd1, 7'h05, 32'h0});
    scan_check("dmi_read_cap", 41, {7'h05, 32'h0, 2'd1});
    pulse_finish(32'hCAFEF00D);
    exp_scan_q.push_back({7'h05, 32'hCAFEF00D, 2'd0});
    scan_check("dmi_read_data", 41, 41'd0);

    exp_scan_q.push_back({7'h05, 32'hCAFEF00D, 2'd0});
    exp_dmi_q.push_back({2'd2, 7'h7F, 32'hFFFFFFFF});
    scan_check("dmi_write2_cap", 41, {7'h7F, 32'hFFFFFFFF, 2'd2});
    ir_scan(6'h10);
    exp_scan_q.push_back(41'h71);
    scan_check("dtmcs_hardreset", 32, 41'h20000);
    ir_scan(6'h11);
    exp_scan_q.push_back({7'h7F, 32'hCAFEF00D, 2'd0});
    scan_check("dmi_after_hardreset", 41, 41'd0);

    check_eq("dmi_start_count", 64'(starts), 64'(3));
    check_eq("dmi_queue_left", 64'(exp_dmi_q.size()), 64'(0));
    check_eq("final_state", 64'(dut.state), 64'(ST_RTI));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
